// File: rtl/vga_rect_fill.sv
// vga_rect_fill: APB master that paints a clipped solid-colour rectangle into
// the VGA framebuffer, one 32-bit write per pixel, in row-major order.
//
// Command handshake: a command is taken on any clock edge where
// cmd_valid && cmd_ready; cmd_ready is high exactly when the engine is idle,
// so there is no queueing and the command fields need only be valid on that edge.
module vga_rect_fill #(
    parameter logic [31:0] BASE_ADDR = 32'h2100_0000,
    parameter int          SCREEN_W  = 640,
    parameter int          SCREEN_H  = 480
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic [9:0]  cmd_x,
    input  logic [8:0]  cmd_y,
    input  logic [9:0]  cmd_w,
    input  logic [8:0]  cmd_h,
    input  logic [23:0] cmd_color,
    output logic        busy,
    output logic        done,
    output logic        err,
    output logic [31:0] paddr,
    output logic        psel,
    output logic        penable,
    output logic        pwrite,
    output logic [31:0] pwdata,
    output logic [3:0]  pstrb,
    output logic [2:0]  pprot,
    input  logic        pready,
    input  logic        pslverr
);

    typedef enum logic [1:0] {IDLE, SETUP, ACCESS, DONE} state_t;

    state_t      state;
    state_t      state_next;

    // Latched command and walk position
    logic [9:0]  x_q;
    logic [8:0]  y_q;
    logic [10:0] ew_q;
    logic [10:0] eh_q;
    logic [23:0] color_q;
    logic [9:0]  col;
    logic [8:0]  row;

    // Clipped extent of the incoming command, 11 bits so nothing wraps
    logic [10:0] clip_w;
    logic [10:0] clip_h;
    logic [10:0] room_w;
    logic [10:0] room_h;

    logic        last_col;
    logic        last_row;
    logic [31:0] pixel_addr;

    // Clip the incoming rectangle against the screen edges
    always_comb begin
        clip_w = 11'd0;
        clip_h = 11'd0;
        room_w = 11'd0;
        room_h = 11'd0;
        if ((11'(cmd_x) < 11'(SCREEN_W)) && (11'(cmd_y) < 11'(SCREEN_H))) begin
            room_w = 11'(SCREEN_W) - 11'(cmd_x);
            room_h = 11'(SCREEN_H) - 11'(cmd_y);
            clip_w = (11'(cmd_w) < room_w) ? 11'(cmd_w) : room_w;
            clip_h = (11'(cmd_h) < room_h) ? 11'(cmd_h) : room_h;
        end
    end

    assign last_col = ({1'b0, col} == (ew_q - 11'd1));
    assign last_row = ({2'b00, row} == (eh_q - 11'd1));

    // Word address of the current pixel; row stride is one screen width
    assign pixel_addr = BASE_ADDR +
        ((((32'(y_q) + 32'(row)) * 32'(SCREEN_W)) + 32'(x_q) + 32'(col)) << 2);

    // Address only shown while selected, so it reads as zero when idle or in reset
    assign paddr     = psel ? pixel_addr : 32'd0;
    assign pwdata    = {8'h00, color_q};
    assign pwrite    = 1'b1;
    assign pstrb     = 4'hF;
    assign pprot     = 3'b000;
    assign cmd_ready = (state == IDLE);

    // State register
    always_ff @(posedge clock) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state and APB control decode
    always_comb begin
        state_next = state;
        psel       = 1'b0;
        penable    = 1'b0;
        case (state)
            IDLE: begin
                if (cmd_valid) begin
                    state_next = ((clip_w == 11'd0) || (clip_h == 11'd0)) ? DONE : SETUP;
                end
            end
            SETUP: begin
                psel       = 1'b1;
                state_next = ACCESS;
            end
            ACCESS: begin
                psel    = 1'b1;
                penable = 1'b1;
                if (pready) begin
                    state_next = (last_col && last_row) ? DONE : SETUP;
                end
            end
            DONE: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Command capture, pixel walk, error accumulation and status flags
    always_ff @(posedge clock) begin
        if (!reset) begin
            x_q     <= '0;
            y_q     <= '0;
            ew_q    <= '0;
            eh_q    <= '0;
            color_q <= '0;
            col     <= '0;
            row     <= '0;
            err     <= 1'b0;
            busy    <= 1'b0;
            done    <= 1'b0;
        end else begin
            done <= (state == DONE);
            case (state)
                IDLE: begin
                    if (cmd_valid) begin
                        x_q     <= cmd_x;
                        y_q     <= cmd_y;
                        ew_q    <= clip_w;
                        eh_q    <= clip_h;
                        color_q <= cmd_color;
                        col     <= '0;
                        row     <= '0;
                        err     <= 1'b0;
                        busy    <= 1'b1;
                    end
                end
                ACCESS: begin
                    if (pready) begin
                        err <= err | pslverr;
                        if (!last_col) begin
                            col <= col + 10'd1;
                        end else if (!last_row) begin
                            col <= '0;
                            row <= row + 9'd1;
                        end
                    end
                end
                DONE: begin
                    busy <= 1'b0;
                end
                default: begin
                end
            endcase
        end
    end

endmodule
